pwm_fade_ctrl: RTL and testbench

- Sequencer that owns the duty_cycle/period inputs of the PWM block driving the board LED.
- Accepts commands over a valid/ready handshake: set duty, ramp to a target, breathe continuously, or stop.
- Duty changes from ramps are applied only at PWM period boundaries, which gives glitch-free fades.
- Sits between user logic and the PWM instance; replaces ad-hoc duty counters in top-level code.

---
 rtl/pwm_ctrl_pkg.sv | 25 ++
 rtl/pwm_step_timer.sv | 46 ++++
 rtl/pwm_fade_ctrl.sv | 134 +++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM fade controller: FSM states, command modes
// and the duty clamp helper.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_RAMP         = 2'b01,
    ST_BREATHE_UP   = 2'b10,
    ST_BREATHE_DOWN = 2'b11
  } state_t;

  localparam logic [1:0] MODE_SET     = 2'b00;
  localparam logic [1:0] MODE_RAMP    = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;
  localparam logic [1:0] MODE_STOP    = 2'b11;

  // Wide enough for any practical WIDTH; callers cast in and out.
  localparam int CLAMP_W = 64;

  function automatic logic [CLAMP_W-1:0] clamp_duty(input logic [CLAMP_W-1:0] value,
                                                     input logic [CLAMP_W-1:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/pwm_step_timer.sv
// Step pacing for the fade controller: counts div clocks per step and holds a
// pending flag until the controller consumes it at a PWM period boundary.
module pwm_step_timer
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int STEP_DIV = 12500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] div,
  input  logic             enable,
  input  logic             consume,
  output logic             step_pending
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] div_q;
  logic             pend_q;
  logic             wrap;

  assign wrap         = enable && (cnt_q == div_q - WIDTH'(1));
  assign step_pending = pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= WIDTH'(STEP_DIV);
      pend_q <= 1'b0;
    end else if (load) begin
      cnt_q  <= '0;
      div_q  <= div;
      pend_q <= 1'b0;
    end else if (enable) begin
      cnt_q <= wrap ? '0 : cnt_q + WIDTH'(1);
      // A wrap in the same cycle as a consume re-arms the flag.
      if (wrap) begin
        pend_q <= 1'b1;
      end else if (consume) begin
        pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Command sequencer driving a PWM block's duty/period: immediate set, stop,
// boundary-aligned ramp to a target, and continuous breathing.
module pwm_fade_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int PERIOD   = 100,
  parameter int STEP_DIV = 12500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic [WIDTH-1:0] cmd_step_div,
  input  logic             pwm_period_end,
  output logic [WIDTH-1:0] duty_cycle,
  output logic [WIDTH-1:0] period,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] PERIOD_W = WIDTH'(PERIOD);

  // Handshake: a command transfers on a clk edge where cmd_valid && cmd_ready;
  // cmd_ready is low only while a RAMP is in flight.

  state_t           state_q, state_n;
  logic [WIDTH-1:0] duty_q, duty_n;
  logic [WIDTH-1:0] tgt_q, tgt_n;
  logic             up_q, up_n;
  logic             done_q, done_n;

  logic             accept;
  logic             step;
  logic             step_pending;
  logic [WIDTH-1:0] tgt_c;
  logic [WIDTH-1:0] div_sel;

  assign cmd_ready  = (state_q != ST_RAMP);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign duty_cycle = duty_q;
  assign period     = PERIOD_W;

  assign accept  = cmd_valid && cmd_ready;
  assign tgt_c   = WIDTH'(clamp_duty(CLAMP_W'(cmd_target), CLAMP_W'(PERIOD)));
  assign div_sel = (cmd_step_div == '0) ? WIDTH'(STEP_DIV) : cmd_step_div;
  // A newly accepted command takes priority over a step due on the same edge.
  assign step    = busy && pwm_period_end && step_pending && !accept;

  pwm_step_timer #(
    .WIDTH    (WIDTH),
    .STEP_DIV (STEP_DIV)
  ) u_step_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (accept),
    .div          (div_sel),
    .enable       (busy),
    .consume      (step),
    .step_pending (step_pending)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      up_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      duty_q  <= duty_n;
      tgt_q   <= tgt_n;
      up_q    <= up_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    duty_n  = duty_q;
    tgt_n   = tgt_q;
    up_n    = up_q;
    done_n  = 1'b0;
    if (accept) begin
      case (cmd_mode)
        MODE_SET: begin
          duty_n  = tgt_c;
          state_n = ST_IDLE;
        end
        MODE_STOP: begin
          duty_n  = '0;
          state_n = ST_IDLE;
        end
        MODE_RAMP: begin
          tgt_n = tgt_c;
          if (tgt_c == duty_q) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_RAMP;
            up_n    = (tgt_c > duty_q);
          end
        end
        default: begin
          state_n = (duty_q == PERIOD_W) ? ST_BREATHE_DOWN : ST_BREATHE_UP;
        end
      endcase
    end else if (step) begin
      case (state_q)
        ST_RAMP: begin
          duty_n = up_q ? duty_q + WIDTH'(1) : duty_q - WIDTH'(1);
          if (duty_n == tgt_q) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end
        ST_BREATHE_UP: begin
          duty_n = duty_q + WIDTH'(1);
          if (duty_n == PERIOD_W) state_n = ST_BREATHE_DOWN;
        end
        ST_BREATHE_DOWN: begin
          duty_n = duty_q - WIDTH'(1);
          if (duty_n == '0) state_n = ST_BREATHE_UP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl with PERIOD=10, STEP_DIV=4 and a PWM
// period-end pulse every 10 clocks.
module tb_pwm_fade_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_mode;
  logic [W-1:0] cmd_target;
  logic [W-1:0] cmd_step_div;
  logic         pe;
  logic [W-1:0] duty_cycle;
  logic [W-1:0] period;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;
  int pe_cnt = 0;

  logic [W-1:0] exp_q[$];

  pwm_fade_ctrl #(.WIDTH(W), .PERIOD(10), .STEP_DIV(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_mode       (cmd_mode),
    .cmd_target     (cmd_target),
    .cmd_step_div   (cmd_step_div),
    .pwm_period_end (pe),
    .duty_cycle     (duty_cycle),
    .period         (period),
    .busy           (busy),
    .done           (done)
  );

  // Clock and the free-running PWM period-end pulse (changes on negedge).
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial pe = 1'b0;
  always @(negedge clk) begin
    pe_cnt = (pe_cnt == 9) ? 0 : pe_cnt + 1;
    pe     = (pe_cnt == 9);
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic send_cmd(input logic [1:0] m, input logic [W-1:0] t, input logic [W-1:0] d);
    cmd_mode     = m;
    cmd_target   = t;
    cmd_step_div = d;
    cmd_valid    = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check_eq("send_timeout_ready", W'(cmd_ready), 1);
    cmd_valid = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W-1:0] prev;
    int steps, dones;
    bit finished, seen_done;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'b00;
    cmd_target = '0; cmd_step_div = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst_duty", duty_cycle, 0);
    check_eq("rst_period", period, 10);
    check_eq("rst_ready", W'(cmd_ready), 1);
    check_eq("rst_busy", W'(busy), 0);
    check_eq("rst_done", W'(done), 0);

    // SET with and without clamping.
    send_cmd(2'b00, 7, 0);
    check_eq("set7_duty", duty_cycle, 7);
    check_eq("set7_busy", W'(busy), 0);
    send_cmd(2'b00, 25, 0);
    check_eq("set25_clamp", duty_cycle, 10);
    check_eq("set25_busy", W'(busy), 0);
    check_eq("set_no_done", W'(done), 0);
    send_cmd(2'b11, 0, 0);
    check_eq("stop_duty", duty_cycle, 0);

    // RAMP 0 -> 3, steps only on period-end edges.
    send_cmd(2'b01, 3, 4);
    check_eq("ramp_busy", W'(busy), 1);
    prev = duty_cycle; steps = 0; dones = 0; finished = 0;
    for (int i = 0; i < 120 && !finished; i++) begin
      tick();
      if (duty_cycle != prev) begin
        steps++;
        check_eq("ramp_step_val", duty_cycle, prev + 1);
        check_eq("ramp_step_on_pe", W'(pe), 1);
        prev = duty_cycle;
      end
      if (done) begin
        dones++;
        finished = 1;
        check_eq("ramp_done_duty", duty_cycle, 3);
        check_eq("ramp_done_busy", W'(busy), 0);
      end else begin
        check_eq("ramp_ready_low", W'(cmd_ready), 0);
      end
    end
    check_eq("ramp_steps", W'(steps), 3);
    check_eq("ramp_done_count", W'(dones), 1);
    tick();
    check_eq("ramp_done_pulse_end", W'(done), 0);
    check_eq("ramp_idle_ready", W'(cmd_ready), 1);

    // RAMP to the current duty: immediate done, no change.
    send_cmd(2'b01, 3, 4);
    check_eq("ramp_eq_done", W'(done), 1);
    check_eq("ramp_eq_duty", duty_cycle, 3);
    check_eq("ramp_eq_busy", W'(busy), 0);
    tick();
    check_eq("ramp_eq_done_end", W'(done), 0);

    // BREATHE from 8: 9,10,9,...,0,1.
    send_cmd(2'b00, 8, 0);
    exp_q = {9, 10};
    for (int v = 9; v >= 0; v--) exp_q.push_back(W'(v));
    exp_q.push_back(1);
    send_cmd(2'b10, 0, 4);
    prev = duty_cycle;
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin
      tick();
      check_eq("breathe_max", W'(duty_cycle <= 10), 1);
      if (duty_cycle != prev) begin
        check_eq("breathe_seq", duty_cycle, exp_q.pop_front());
        check_eq("breathe_on_pe", W'(pe), 1);
        check_eq("breathe_busy", W'(busy), 1);
        prev = duty_cycle;
      end
    end
    check_eq("breathe_seq_left", W'(exp_q.size()), 0);

    // Preempt BREATHE_DOWN at 5 with STOP.
    send_cmd(2'b00, 10, 0);
    send_cmd(2'b10, 0, 4);
    for (int i = 0; i < 200 && duty_cycle != 5; i++) tick();
    check_eq("pre_duty5", duty_cycle, 5);
    check_eq("pre_busy", W'(busy), 1);
    check_eq("pre_ready", W'(cmd_ready), 1);
    send_cmd(2'b11, 0, 0);
    check_eq("pre_stop_duty", duty_cycle, 0);
    check_eq("pre_stop_busy", W'(busy), 0);

    // Command held valid during RAMP waits until the ramp finishes.
    send_cmd(2'b01, 2, 1);
    cmd_mode = 2'b00; cmd_target = 9; cmd_step_div = 0; cmd_valid = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 100 && duty_cycle != 9; i++) begin
      tick();
      if (done) seen_done = 1;
    end
    cmd_valid = 1'b0;
    check_eq("hold_final_duty", duty_cycle, 9);
    check_eq("hold_done_first", W'(seen_done), 1);

    // Asynchronous reset in the middle of a ramp.
    send_cmd(2'b01, 0, 1);
    for (int i = 0; i < 100 && duty_cycle > 7; i++) tick();
    check_eq("mid_busy", W'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_duty", duty_cycle, 0);
    check_eq("arst_period", period, 10);
    check_eq("arst_ready", W'(cmd_ready), 1);
    check_eq("arst_busy", W'(busy), 0);
    check_eq("arst_done", W'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) tick();
    check_eq("post_rst_duty", duty_cycle, 0);
    check_eq("post_rst_busy", W'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
